// File: rtl/upload_word_packer_if.sv
// upload_word_packer_if: byte upload stream in, packed word memory writes out.
//   i_clk_enable      : qualifies every state update of the packer
//   i_byte_we/addr/data: byte write stream from upload_rx
//   i_upload_complete : level, upload finished
//   i_mem_ready       : memory accepts the pending word write
//   o_mem_*           : word write request, word address, packed data, byte enables
//   o_cpu_reset       : CPU held in reset until boot
//   o_loaded_words    : accepted word writes, wraps at 2^16
//   o_error           : sticky address/overflow error
interface upload_word_packer_if;
    logic        i_clk_enable;
    logic        i_byte_we;
    logic [31:0] i_byte_addr;
    logic [7:0]  i_byte_data;
    logic        i_upload_complete;
    logic        i_mem_ready;
    logic        o_mem_we;
    logic [29:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        o_cpu_reset;
    logic [15:0] o_loaded_words;
    logic        o_error;

    modport master (
        output i_clk_enable, i_byte_we, i_byte_addr, i_byte_data, i_upload_complete, i_mem_ready,
        input  o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_cpu_reset, o_loaded_words, o_error
    );

    modport slave (
        input  i_clk_enable, i_byte_we, i_byte_addr, i_byte_data, i_upload_complete, i_mem_ready,
        output o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_cpu_reset, o_loaded_words, o_error
    );
endinterface

// File: rtl/upload_word_packer.sv
// upload_word_packer: packs the upload byte stream into little-endian 32-bit word writes,
// flushes a partial word on completion, then releases the CPU after BOOT_DELAY enabled cycles.
//   clk   : single clock
//   reset : synchronous, active-high
//   bus   : upload_word_packer_if.slave (byte stream in, memory write handshake out, status)
module upload_word_packer #(
    parameter int BOOT_DELAY = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    upload_word_packer_if.slave  bus
);
    localparam int CW = $clog2(BOOT_DELAY + 1);

    typedef enum logic [2:0] {COLLECT, WRITE, FLUSH, BOOT_WAIT, RUN} state_t;

    typedef struct packed {
        state_t        state;
        logic          mem_we;
        logic [29:0]   mem_addr;
        logic [31:0]   mem_wdata;
        logic [3:0]    mem_be;
        logic          cpu_reset;
        logic [15:0]   loaded_words;
        logic          error;
        logic [31:0]   expected;
        logic          skid_v;
        logic [31:0]   skid_addr;
        logic [7:0]    skid_data;
        logic [CW-1:0] boot_cnt;
    } regs_t;

    regs_t       r_cur;
    regs_t       w_nxt;
    logic        w_src_v;
    logic [31:0] w_src_addr;
    logic [7:0]  w_src_data;

    // A held skid byte is older than any live byte, so it is always consumed first.
    assign w_src_v    = r_cur.skid_v || bus.i_byte_we;
    assign w_src_addr = r_cur.skid_v ? r_cur.skid_addr : bus.i_byte_addr;
    assign w_src_data = r_cur.skid_v ? r_cur.skid_data : bus.i_byte_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur           <= '0;
            r_cur.cpu_reset <= 1'b1;
        end else if (bus.i_clk_enable) begin
            r_cur <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_cur;
        case (r_cur.state)
            COLLECT: begin
                if (w_src_v) begin
                    // Draining the skid frees it for a live byte arriving in the same cycle.
                    if (r_cur.skid_v) begin
                        w_nxt.skid_v    = bus.i_byte_we;
                        w_nxt.skid_addr = bus.i_byte_addr;
                        w_nxt.skid_data = bus.i_byte_data;
                    end
                    if (w_src_addr != r_cur.expected) begin
                        w_nxt.error = 1'b1;
                    end else begin
                        w_nxt.mem_wdata[{w_src_addr[1:0], 3'b000} +: 8] = w_src_data;
                        w_nxt.mem_be   = r_cur.mem_be | (4'b0001 << w_src_addr[1:0]);
                        w_nxt.mem_addr = w_src_addr[31:2];
                        w_nxt.expected = r_cur.expected + 32'd1;
                        w_nxt.mem_we   = &w_src_addr[1:0];
                        w_nxt.state    = (&w_src_addr[1:0]) ? WRITE : COLLECT;
                    end
                end else if (bus.i_upload_complete) begin
                    w_nxt.mem_we = |r_cur.mem_be;
                    w_nxt.state  = (|r_cur.mem_be) ? FLUSH : BOOT_WAIT;
                end
            end
            WRITE, FLUSH: begin
                if (bus.i_byte_we) begin
                    w_nxt.error     = r_cur.error | r_cur.skid_v;
                    w_nxt.skid_v    = 1'b1;
                    w_nxt.skid_addr = r_cur.skid_v ? r_cur.skid_addr : bus.i_byte_addr;
                    w_nxt.skid_data = r_cur.skid_v ? r_cur.skid_data : bus.i_byte_data;
                end
                if (bus.i_mem_ready) begin
                    w_nxt.mem_we       = 1'b0;
                    w_nxt.mem_wdata    = '0;
                    w_nxt.mem_be       = '0;
                    w_nxt.loaded_words = r_cur.loaded_words + 16'd1;
                    w_nxt.state        = (r_cur.state == WRITE) ? COLLECT : BOOT_WAIT;
                end
            end
            BOOT_WAIT: begin
                if (r_cur.boot_cnt == CW'(BOOT_DELAY - 1)) begin
                    w_nxt.cpu_reset = 1'b0;
                    w_nxt.state     = RUN;
                end else begin
                    w_nxt.boot_cnt = r_cur.boot_cnt + CW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.o_mem_we       = r_cur.mem_we;
    assign bus.o_mem_addr     = r_cur.mem_addr;
    assign bus.o_mem_wdata    = r_cur.mem_wdata;
    assign bus.o_mem_be       = r_cur.mem_be;
    assign bus.o_cpu_reset    = r_cur.cpu_reset;
    assign bus.o_loaded_words = r_cur.loaded_words;
    assign bus.o_error        = r_cur.error;
endmodule

// File: tb/tb_upload_word_packer.sv
// tb_upload_word_packer: directed and randomized checks of upload_word_packer against a word-level model.
module tb_upload_word_packer;
    localparam int BD = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    upload_word_packer_if bus();

    upload_word_packer #(.BOOT_DELAY(BD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t         got_q[$];
    int          checks = 0;
    int          errors = 0;
    int          en_cnt = 0;
    int          ack_at = 0;
    int unsigned en_pct = 100;
    int unsigned rdy_pct = 100;

    // Observe accepted memory writes and number every enabled edge.
    always @(posedge clk) begin
        if (!reset && bus.i_clk_enable) begin
            en_cnt = en_cnt + 1;
            if (bus.o_mem_we && bus.i_mem_ready) begin
                got_q.push_back('{a: bus.o_mem_addr, d: bus.o_mem_wdata, be: bus.o_mem_be});
                ack_at = en_cnt;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rtick();
        bus.i_clk_enable = ($urandom_range(99) < en_pct);
        bus.i_mem_ready  = ($urandom_range(99) < rdy_pct);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.i_clk_enable = 1'b1;
        bus.i_byte_we = 1'b0;
        bus.i_byte_addr = '0;
        bus.i_byte_data = '0;
        bus.i_upload_complete = 1'b0;
        bus.i_mem_ready = 1'b0;
        tick();
        reset = 1'b0;
        got_q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"}, bus.o_mem_we, 0);
        chk({tag, "_addr"}, bus.o_mem_addr, 0);
        chk({tag, "_wdata"}, bus.o_mem_wdata, 0);
        chk({tag, "_be"}, bus.o_mem_be, 0);
        chk({tag, "_cpu_reset"}, bus.o_cpu_reset, 1);
        chk({tag, "_loaded"}, bus.o_loaded_words, 0);
        chk({tag, "_error"}, bus.o_error, 0);
    endtask

    // Presents one byte only while no write is pending and holds it until an enabled edge.
    task automatic send(input logic [31:0] a, input logic [7:0] d);
        int b = 0;
        while (bus.o_mem_we && b < 300) begin
            rtick();
            b++;
        end
        if (b >= 300) timeout("send_wait");
        bus.i_byte_we = 1'b1;
        bus.i_byte_addr = a;
        bus.i_byte_data = d;
        do rtick(); while (!bus.i_clk_enable);
        bus.i_byte_we = 1'b0;
    endtask

    // Uploads n bytes from address 0, completes, waits for boot and checks everything against the model.
    task automatic upload_and_boot(input int n, input logic [7:0] base, input bit rnd, input bit bad);
        logic [7:0] bytes[$];
        logic       model_err = 1'b0;
        int         nw = (n + 3) / 4;
        int         exp_fall = 0;
        int         b = 0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] d = rnd ? 8'($urandom) : base + 8'(i);
            bytes.push_back(d);
            if (bad && $urandom_range(5) == 0) begin
                send(32'(i + 1 + $urandom_range(5)), 8'($urandom));
                model_err = 1'b1;
            end
            send(32'(i), d);
        end
        if (n % 4 == 0) begin
            while (bus.o_loaded_words != 16'(n / 4) && b < 500) begin
                rtick();
                b++;
            end
            if (b >= 500) timeout("loaded_wait");
            exp_fall = en_cnt + 1 + BD;
            bus.i_upload_complete = 1'b1;
        end else begin
            bus.i_upload_complete = 1'b1;
        end
        b = 0;
        while (bus.o_cpu_reset && b < 3000) begin
            rtick();
            b++;
        end
        if (b >= 3000) timeout("boot_wait");
        if (n % 4 != 0) exp_fall = ack_at + BD;
        chk("boot_delay", en_cnt, exp_fall);
        chk("nwrites", got_q.size(), nw);
        for (int w = 0; w < nw && w < got_q.size(); w++) begin
            logic [31:0] d = '0;
            logic [3:0]  be = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * w + k < n) begin
                    d[8*k +: 8] = bytes[4*w+k];
                    be[k] = 1'b1;
                end
            end
            chk("w_addr", got_q[w].a, w);
            chk("w_data", got_q[w].d, d);
            chk("w_be", got_q[w].be, be);
        end
        chk("loaded", bus.o_loaded_words, nw);
        chk("error", bus.o_error, model_err);
        send(32'(n), 8'h5A);
        send(32'(n + 7), 8'hA5);
        chk("run_loaded", bus.o_loaded_words, nw);
        chk("run_be", bus.o_mem_be, 0);
        chk("run_we", bus.o_mem_we, 0);
        chk("run_error", bus.o_error, model_err);
        chk("run_cpu_reset", bus.o_cpu_reset, 0);
    endtask

    initial begin
        do_reset();
        chk_reset("rst");

        // Single full word with memory always ready.
        bus.i_mem_ready = 1'b1;
        send(0, 8'h11);
        send(1, 8'h22);
        send(2, 8'h33);
        send(3, 8'h44);
        chk("t1_we", bus.o_mem_we, 1);
        chk("t1_addr", bus.o_mem_addr, 0);
        chk("t1_wdata", bus.o_mem_wdata, 32'h44332211);
        chk("t1_be", bus.o_mem_be, 4'hF);
        tick();
        chk("t1_loaded", bus.o_loaded_words, 1);
        chk("t1_we_low", bus.o_mem_we, 0);
        chk("t1_nwrites", got_q.size(), 1);

        // Six bytes with a flushed partial word; boot exactly BD enabled cycles after the flush ack.
        do_reset();
        upload_and_boot(6, 8'hA0, 1'b0, 1'b0);

        // Stalled memory: one byte skids, the next overflows, skid byte opens the next word.
        do_reset();
        rdy_pct = 0;
        for (int i = 0; i < 4; i++) send(32'(i), 8'hC0 + 8'(i));
        bus.i_mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.i_byte_we = (i == 2) || (i == 5);
            bus.i_byte_addr = (i == 2) ? 32'd4 : 32'd5;
            bus.i_byte_data = (i == 2) ? 8'hC4 : 8'hC5;
            tick();
            chk("stall_wdata", bus.o_mem_wdata, 32'hC3C2C1C0);
            chk("stall_we", bus.o_mem_we, 1);
            if (i == 3) chk("skid_no_err", bus.o_error, 0);
        end
        bus.i_byte_we = 1'b0;
        chk("overflow_err", bus.o_error, 1);
        bus.i_mem_ready = 1'b1;
        tick();
        chk("stall_ack_loaded", bus.o_loaded_words, 1);
        chk("stall_ack_we", bus.o_mem_we, 0);
        tick();
        chk("skid_be", bus.o_mem_be, 4'h1);
        chk("skid_wdata", bus.o_mem_wdata, 32'h000000C4);
        chk("skid_addr", bus.o_mem_addr, 1);
        rdy_pct = 100;

        // Wrong address is dropped with an error; the correct one is then accepted.
        do_reset();
        send(2, 8'h77);
        chk("bad_err", bus.o_error, 1);
        chk("bad_be", bus.o_mem_be, 0);
        chk("bad_we", bus.o_mem_we, 0);
        send(0, 8'h88);
        chk("good_be", bus.o_mem_be, 4'h1);
        chk("good_wdata", bus.o_mem_wdata, 32'h00000088);

        // Reset in the middle of a pending write, then a clean upload.
        do_reset();
        rdy_pct = 0;
        for (int i = 0; i < 4; i++) send(32'(i), 8'h30 + 8'(i));
        chk("mid_we", bus.o_mem_we, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        got_q.delete();
        chk_reset("mid_rst");
        rdy_pct = 100;
        upload_and_boot(4, 8'h60, 1'b0, 1'b0);

        // Gated clock enable during a 4-byte upload.
        do_reset();
        en_pct = 50;
        upload_and_boot(4, 8'h51, 1'b0, 1'b0);

        // Zero-byte upload.
        do_reset();
        en_pct = 100;
        upload_and_boot(0, 8'h00, 1'b0, 1'b0);

        // Randomized uploads with gated enables, random ready and stray addresses.
        for (int t = 0; t < 10; t++) begin
            en_pct = 40 + $urandom_range(60);
            rdy_pct = 30 + $urandom_range(70);
            do_reset();
            upload_and_boot(int'($urandom_range(13)), 8'h00, 1'b1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
